// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO write arbiter: op encodings and FSM states.
package gpio_pkg;

  localparam int GPIO_OP_W = 2;

  typedef enum logic [GPIO_OP_W-1:0] {
    GPIO_OP_WRITE  = 2'b00,
    GPIO_OP_SET    = 2'b01,
    GPIO_OP_CLEAR  = 2'b10,
    GPIO_OP_TOGGLE = 2'b11
  } gpio_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } gpio_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int c;
    logic [IW-1:0] cidx;
    c       = 0;
    cidx    = '0;
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      // ptr_i is always below N, so a single subtraction completes the wrap.
      c = int'(ptr_i) + k;
      if (c >= N) c = c - N;
      cidx = IW'(c);
      if (!valid_o && req_i[cidx]) begin
        valid_o       = 1'b1;
        idx_o         = cidx;
        grant_o[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_wr_arbiter.sv
// Round-robin owner of the GPIO register write port; one WRITE/SET/CLEAR/TOGGLE per grant.
module gpio_wr_arbiter
  import gpio_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [DW*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic                 gpio_we,
  output logic [DW-1:0]        gpio_wdata,
  input  logic [DW-1:0]        gpio_rdata
);

  localparam int IW = $clog2(NUM_REQ);

  gpio_state_e   state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_q, win_d;
  gpio_op_e      op_q, op_d;
  logic [DW-1:0] data_q, data_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IW-1:0]      arb_idx;
  logic               arb_valid;
  gpio_op_e           op_sel;
  logic [DW-1:0]      data_sel;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    op_sel   = GPIO_OP_WRITE;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) begin
        op_sel   = gpio_op_e'(req_op[2*i +: 2]);
        data_sel = req_data[DW*i +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= GPIO_OP_WRITE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_d   = arb_idx;
          op_d    = op_sel;
          data_d  = data_sel;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        ptr_d   = (win_q == IW'(NUM_REQ-1)) ? '0 : win_q + IW'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode only registered state; wdata folds in live rdata so the RMW sees the current value.
  always_comb begin
    busy       = (state_q == ST_ISSUE);
    gpio_we    = busy;
    ack        = '0;
    gpio_wdata = '0;
    if (busy) begin
      ack[win_q] = 1'b1;
      case (op_q)
        GPIO_OP_WRITE:  gpio_wdata = data_q;
        GPIO_OP_SET:    gpio_wdata = gpio_rdata | data_q;
        GPIO_OP_CLEAR:  gpio_wdata = gpio_rdata & ~data_q;
        GPIO_OP_TOGGLE: gpio_wdata = gpio_rdata ^ data_q;
        default:        gpio_wdata = data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_wr_arbiter.sv
// Bench for gpio_wr_arbiter: transaction-level model plus directed scenarios with literal results.
module tb_gpio_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [3:0]  req_op = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  ack;
  logic        busy;
  logic        gpio_we;
  logic [7:0]  gpio_wdata;
  logic [7:0]  gpio_reg = 8'h00;

  int checks = 0;
  int errors = 0;

  gpio_wr_arbiter #(.NUM_REQ(2), .DW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_op     (req_op),
    .req_data   (req_data),
    .ack        (ack),
    .busy       (busy),
    .gpio_we    (gpio_we),
    .gpio_wdata (gpio_wdata),
    .gpio_rdata (gpio_reg)
  );

  always #5 clk = ~clk;

  // The GPIO register itself: not touched by the arbiter's reset.
  always @(posedge clk) if (gpio_we) gpio_reg <= gpio_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] apply_op(input logic [1:0] op, input logic [7:0] r, input logic [7:0] d);
    case (op)
      2'b00:   return d;
      2'b01:   return r | d;
      2'b10:   return r & ~d;
      default: return r ^ d;
    endcase
  endfunction

  // Model: a granted request becomes one write of apply_op(current reg) in the following cycle.
  bit         m_issue = 1'b0;
  int         m_who = 0;
  int         m_ptr = 0;
  int         m_idx;
  logic [7:0] m_val = 8'h00;
  logic [7:0] m_reg = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_issue = 1'b0;
      m_ptr   = 0;
      m_who   = 0;
      m_val   = 8'h00;
    end else if (m_issue) begin
      m_reg   = m_val;
      m_issue = 1'b0;
      m_ptr   = (m_who + 1) % 2;
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_idx = (m_ptr + k) % 2;
        if (!m_issue && req[m_idx]) begin
          m_issue = 1'b1;
          m_who   = m_idx;
          m_val   = apply_op(req_op[2*m_idx +: 2], m_reg, req_data[8*m_idx +: 8]);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_we", gpio_we, m_issue);
    check("cmp_busy", busy, m_issue);
    check("cmp_ack", ack, m_issue ? (2'b01 << m_who) : 2'b00);
    check("cmp_wdata", gpio_wdata, m_issue ? m_val : 8'h00);
    check("cmp_reg", gpio_reg, m_reg);
  end

  task automatic single_op(input int i, input logic [1:0] op, input logic [7:0] d,
                           input logic [7:0] exp_reg, input string name);
    int n;
    bit got;
    @(posedge clk); #1;
    req[i] = 1'b1;
    req_op[2*i +: 2] = op;
    req_data[8*i +: 8] = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 10) begin
      @(negedge clk);
      n++;
      if (ack[i]) got = 1'b1;
    end
    check({name, "_latency"}, n, 2);
    @(posedge clk); #1;
    req[i] = 1'b0;
    check({name, "_ack_one_cycle"}, ack, 2'b00);
    @(negedge clk);
    check({name, "_reg"}, gpio_reg, exp_reg);
  endtask

  task automatic contend(input int exp_first, input logic [7:0] exp_final, input string name);
    int c0, c1, cyc;
    c0 = -1; c1 = -1; cyc = 0;
    @(posedge clk); #1;
    req_op = 4'b0000;
    req_data = {8'h22, 8'h11};
    req = 2'b11;
    while ((c0 < 0 || c1 < 0) && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (ack[0] && c0 < 0) c0 = cyc;
      if (ack[1] && c1 < 0) c1 = cyc;
      @(posedge clk); #1;
      if (c0 >= 0) req[0] = 1'b0;
      if (c1 >= 0) req[1] = 1'b0;
    end
    req = 2'b00;
    check({name, "_first"}, (c0 >= 0 && c0 < c1) ? 0 : 1, exp_first);
    check({name, "_gap"}, (exp_first == 0) ? c1 - c0 : c0 - c1, 2);
    @(negedge clk);
    check({name, "_final_reg"}, gpio_reg, exp_final);
  endtask

  initial begin
    int n, grants, cyc, prev_who;
    bit prev_we;

    repeat (2) @(posedge clk);
    #1;
    check("reset_we", gpio_we, 1'b0);
    check("reset_ack", ack, 2'b00);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;

    single_op(0, 2'b00, 8'hA5, 8'hA5, "write");
    single_op(0, 2'b00, 8'hF0, 8'hF0, "preload");
    single_op(1, 2'b01, 8'h0F, 8'hFF, "set");
    single_op(0, 2'b10, 8'h30, 8'hCF, "clear");
    single_op(1, 2'b11, 8'hFF, 8'h30, "toggle");

    // Data/op changed after grant must not reach the register.
    @(posedge clk); #1;
    req[0] = 1'b1; req_op[1:0] = 2'b00; req_data[7:0] = 8'h3C;
    @(posedge clk); #1;
    req_op[1:0] = 2'b11; req_data[7:0] = 8'h99;
    @(negedge clk);
    check("latch_ack", ack, 2'b01);
    check("latch_wdata", gpio_wdata, 8'h3C);
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(negedge clk);
    check("latch_reg", gpio_reg, 8'h3C);

    // Reset in the middle of ISSUE: no write escapes.
    @(posedge clk); #1;
    req[1] = 1'b1; req_op[3:2] = 2'b00; req_data[15:8] = 8'h77;
    @(posedge clk); #1;
    check("midrst_busy_before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_we", gpio_we, 1'b0);
    check("midrst_ack", ack, 2'b00);
    check("midrst_busy", busy, 1'b0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_reg", gpio_reg, 8'h3C);

    contend(0, 8'h22, "contend_ptr0");
    single_op(0, 2'b00, 8'h55, 8'h55, "move_ptr");
    contend(1, 8'h11, "contend_ptr1");

    // Back-to-back: both requests held high across 20 grants.
    grants = 0; cyc = 0; prev_who = -1; prev_we = 1'b0;
    @(posedge clk); #1;
    req_op = 4'b0000;
    req_data = {8'h40, 8'h80};
    req = 2'b11;
    while (grants < 20 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      check("b2b_we", gpio_we & prev_we, 1'b0);
      prev_we = gpio_we;
      if (ack != 2'b00) begin
        if (prev_who < 0) check("fair_first", ack[1], 1'b1);
        else              check("fair_alt", ack[1], (prev_who == 0) ? 1'b1 : 1'b0);
        prev_who = ack[1] ? 1 : 0;
        grants++;
      end
      @(posedge clk); #1;
      req_data = {8'(8'h40 + grants), 8'(8'h80 + grants)};
    end
    req = 2'b00;
    check("fair_grants", grants, 20);

    repeat (4) @(negedge clk);
    n = checks;
    $display("Simulation finished: %0d checks, %0d errors", n, errors);
    $finish;
  end

endmodule
